// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller handshake bundle: pipeline status in, stall/flush controls out.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if;
  logic [4:0] ID_rsAddr;
  logic [4:0] ID_rtAddr;
  logic       ID_UsesRs;
  logic       ID_UsesRt;
  logic       EX_MemtoReg;
  logic [4:0] EX_wAddr;
  logic       EX_Taken;
  logic       EX_MduStart;
  logic       MEM_Req;
  logic       MEM_Ready;
  logic       PC_stall;
  logic       IF_ID_stall;
  logic       IF_ID_flush;
  logic       ID_EX_clr;
  logic       EX_stall;

  modport master (
    output ID_rsAddr, ID_rtAddr, ID_UsesRs, ID_UsesRt,
    output EX_MemtoReg, EX_wAddr, EX_Taken, EX_MduStart,
    output MEM_Req, MEM_Ready,
    input  PC_stall, IF_ID_stall, IF_ID_flush,
    input  ID_EX_clr, EX_stall
  );

  modport slave (
    input  ID_rsAddr, ID_rtAddr, ID_UsesRs, ID_UsesRt,
    input  EX_MemtoReg, EX_wAddr, EX_Taken, EX_MduStart,
    input  MEM_Req, MEM_Ready,
    output PC_stall, IF_ID_stall, IF_ID_flush,
    output ID_EX_clr, EX_stall
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, redirect, MDU, dmem wait).
// Optional perf counters built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] MDU_INIT = 8'(MDU_LAT - 2);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       res_q, res_d;
  logic       hold;
  logic       bubble;
  logic       redirect;
  logic       load_use;
  logic       mem_miss;

  assign mem_miss = hz.MEM_Req & ~hz.MEM_Ready;

  assign load_use = hz.EX_MemtoReg & (hz.EX_wAddr != 5'd0) &
    ((hz.ID_UsesRs & (hz.ID_rsAddr == hz.EX_wAddr)) |
     (hz.ID_UsesRt & (hz.ID_rtAddr == hz.EX_wAddr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    hold     = 1'b0;
    bubble   = 1'b0;
    redirect = 1'b0;
    unique case (state_q)
      MEM_WAIT: begin
        // res_q remembers an MDU op frozen underneath the memory wait
        if (hz.MEM_Ready) begin
          state_d = res_q ? MDU_BUSY : RUN;
          res_d   = 1'b0;
        end else begin
          hold = 1'b1;
        end
      end
      MDU_BUSY: begin
        if (mem_miss) begin
          hold    = 1'b1;
          res_d   = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          redirect = hz.EX_Taken;
          if (cnt_q != 8'd0) begin
            hold  = ~hz.EX_Taken;
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: begin
        if (mem_miss) begin
          hold    = 1'b1;
          res_d   = 1'b0;
          state_d = MEM_WAIT;
        end else if (hz.EX_Taken) begin
          redirect = 1'b1;
        end else if (hz.EX_MduStart) begin
          hold    = 1'b1;
          cnt_d   = MDU_INIT;
          state_d = MDU_BUSY;
        end else begin
          bubble = load_use;
        end
      end
    endcase
  end

  assign hz.PC_stall    = hold | bubble;
  assign hz.IF_ID_stall = hold | bubble;
  assign hz.EX_stall    = hold;
  assign hz.IF_ID_flush = redirect;
  assign hz.ID_EX_clr   = redirect | bubble;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(hold | bubble);
      flush_cnt <= flush_cnt + CNT_W'(redirect);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MDU_LAT=4).
// Expected outputs come from a cycle model pushed at drive time.
module tb_pipeline_hazard_ctrl;
  localparam int LAT = 4;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hz        (hz.slave),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mto;
    logic [4:0] wa;
    logic       tk;
    logic       ms;
    logic       req;
    logic       rdy;
  } stim_t;

  typedef struct {
    bit pc, ifid, fl, clr, exs;
    int unsigned sc, fc;
  } exp_t;

  typedef enum {M_RUN, M_MDU, M_MEM} mst_t;

  exp_t q[$];
  mst_t m_st = M_RUN;
  int   m_cnt = 0;
  bit   m_res = 0;
  int unsigned m_sc = 0;
  int unsigned m_fc = 0;

  localparam stim_t IDLE = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    hz.ID_rsAddr   = s.rs;
    hz.ID_rtAddr   = s.rt;
    hz.ID_UsesRs   = s.urs;
    hz.ID_UsesRt   = s.urt;
    hz.EX_MemtoReg = s.mto;
    hz.EX_wAddr    = s.wa;
    hz.EX_Taken    = s.tk;
    hz.EX_MduStart = s.ms;
    hz.MEM_Req     = s.req;
    hz.MEM_Ready   = s.rdy;
  endtask

  task automatic model(input stim_t s);
    exp_t e;
    bit lu, h;
    e = '{default: 0};
    e.sc = PERF ? m_sc : 0;
    e.fc = PERF ? m_fc : 0;
    lu = s.mto && s.wa != 0 &&
         ((s.urs && s.rs == s.wa) || (s.urt && s.rt == s.wa));
    h = 0;
    if (m_st == M_MEM) begin
      if (s.rdy) begin
        m_st = m_res ? M_MDU : M_RUN;
        m_res = 0;
      end else h = 1;
    end else if (s.req && !s.rdy) begin
      h = 1;
      m_res = (m_st == M_MDU);
      m_st = M_MEM;
    end else if (m_st == M_MDU) begin
      if (s.tk) begin
        e.fl = 1; e.clr = 1;
      end
      if (m_cnt != 0) begin
        h = !s.tk;
        m_cnt--;
      end else m_st = M_RUN;
    end else if (s.tk) begin
      e.fl = 1; e.clr = 1;
    end else if (s.ms) begin
      h = 1;
      m_cnt = LAT - 2;
      m_st = M_MDU;
    end else if (lu) begin
      e.pc = 1; e.ifid = 1; e.clr = 1;
    end
    if (h) begin
      e.pc = 1; e.ifid = 1; e.exs = 1;
    end
    if (e.pc) m_sc++;
    if (e.fl) m_fc++;
    q.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_pc"},   32'(hz.PC_stall),    32'(e.pc));
    chk({tag, "_ifid"}, 32'(hz.IF_ID_stall), 32'(e.ifid));
    chk({tag, "_fl"},   32'(hz.IF_ID_flush), 32'(e.fl));
    chk({tag, "_clr"},  32'(hz.ID_EX_clr),   32'(e.clr));
    chk({tag, "_exs"},  32'(hz.EX_stall),    32'(e.exs));
    chk({tag, "_sc"},   stall_cnt,           e.sc);
    chk({tag, "_fc"},   flush_cnt,           e.fc);
  endtask

  task automatic cyc(input string tag, input stim_t s);
    @(posedge clk);
    #1;
    drive(s);
    model(s);
    @(negedge clk);
    compare(tag);
  endtask

  function automatic stim_t lus(input logic [4:0] wa, input logic [4:0] rs,
                                input logic urs, input logic [4:0] rt,
                                input logic urt);
    stim_t s;
    s = IDLE;
    s.mto = 1'b1; s.wa = wa;
    s.rs = rs; s.urs = urs;
    s.rt = rt; s.urt = urt;
    return s;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    drive(IDLE);
    #12;
    chk("rst_pc", 32'(hz.PC_stall), 32'd0);
    chk("rst_exs", 32'(hz.EX_stall), 32'd0);
    chk("rst_clr", 32'(hz.ID_EX_clr), 32'd0);
    chk("rst_sc", stall_cnt, 32'd0);
    chk("rst_fc", flush_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc("idle", IDLE);
    cyc("lu_rs", lus(5'd2, 5'd2, 1'b1, 5'd0, 1'b0));
    cyc("lu_rt", lus(5'd7, 5'd3, 1'b1, 5'd7, 1'b1));
    cyc("r0_nohaz", lus(5'd0, 5'd0, 1'b1, 5'd0, 1'b1));
    cyc("rt_unused", lus(5'd2, 5'd5, 1'b1, 5'd2, 1'b0));
    cyc("not_load", IDLE);
    s = lus(5'd2, 5'd2, 1'b1, 5'd0, 1'b0);
    s.tk = 1'b1;
    cyc("tk_over_lu", s);
    cyc("after_tk", IDLE);

    s = IDLE; s.ms = 1'b1;
    cyc("mdu_start", s);
    for (int i = 0; i < LAT; i++) cyc("mdu_run", IDLE);

    s = IDLE; s.req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("mem_wait", s);
    s.rdy = 1'b1;
    cyc("mem_ready", s);
    cyc("mem_hit", s);
    cyc("post_mem", IDLE);

    s = IDLE; s.ms = 1'b1;
    cyc("mdu_mem_st", s);
    cyc("mdu_mem_b", IDLE);
    s = IDLE; s.req = 1'b1;
    cyc("mdu_mem_w", s);
    cyc("mdu_mem_w", s);
    s.rdy = 1'b1;
    cyc("mdu_mem_r", s);
    for (int i = 0; i < LAT; i++) cyc("mdu_resume", IDLE);

    for (int i = 0; i < 80; i++) begin
      s = IDLE;
      s.rs  = 5'($urandom_range(0, 3));
      s.rt  = 5'($urandom_range(0, 3));
      s.urs = 1'($urandom_range(0, 1));
      s.urt = 1'($urandom_range(0, 1));
      s.mto = 1'($urandom_range(0, 1));
      s.wa  = 5'($urandom_range(0, 3));
      s.tk  = ($urandom_range(0, 7) == 0);
      s.ms  = ($urandom_range(0, 7) == 0);
      s.req = ($urandom_range(0, 3) == 0);
      s.rdy = ($urandom_range(0, 1) == 0);
      cyc("rand", s);
    end

    s = IDLE; s.ms = 1'b1;
    cyc("rst_mdu_st", s);
    cyc("rst_mdu_b", IDLE);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", 32'(hz.PC_stall), 32'd0);
    chk("arst_ifid", 32'(hz.IF_ID_stall), 32'd0);
    chk("arst_exs", 32'(hz.EX_stall), 32'd0);
    chk("arst_sc", stall_cnt, 32'd0);
    chk("arst_fc", flush_cnt, 32'd0);
    m_st = M_RUN; m_cnt = 0; m_res = 0; m_sc = 0; m_fc = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst", IDLE);
    cyc("post_rst_lu", lus(5'd9, 5'd9, 1'b1, 5'd0, 1'b0));
    cyc("post_rst2", IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
